// File: rtl/wshb_frame_reader.sv
// Wishbone burst reader filling a show-ahead pixel FIFO from a linear framebuffer (option: WSHB_ERR_RETRY_EN).
// Latency: a burst starts 1 cycle after BURST_LEN FIFO slots are free; a pixel is visible 1 cycle after its ack.
// Backpressure: bursts are only issued when the FIFO can absorb a whole burst; pix_rd on empty is ignored.
module wshb_frame_reader #(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] wshb_adr,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    output logic [31:0] wshb_dat_ms,
    input  logic [31:0] wshb_dat_sm,
    input  logic        wshb_ack,
    input  logic        wshb_err,
    input  logic        wshb_rty,
    input  logic        frame_sync,
    input  logic        pix_rd,
    output logic [31:0] pix_data,
    output logic        pix_empty
);
    localparam int TOTAL  = HDISP * VDISP;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [31:0]       LAST_PIX  = 32'(TOTAL - 1);

    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;

    logic [31:0]       adr_q;
    logic [31:0]       pix_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic              discard;

    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  free;

    logic              in_burst;
    logic              beat_ok;
    logic              beat_fail;
    logic              last_beat;
    logic              room;
    logic              push;
    logic              pop;
    logic [31:0]       push_dat;

    assign in_burst  = (state == BURST);
    assign last_beat = (beat_cnt == LAST_BEAT);

`ifdef WSHB_ERR_RETRY_EN
    assign beat_fail = in_burst & (wshb_err | wshb_rty);
    assign beat_ok   = in_burst & wshb_ack & ~beat_fail;
    assign push_dat  = wshb_dat_sm;
`else
    // A faulted beat still completes so the frame keeps its geometry; it carries a black pixel.
    assign beat_fail = 1'b0;
    assign beat_ok   = in_burst & (wshb_ack | wshb_err | wshb_rty);
    assign push_dat  = (wshb_err | wshb_rty) ? 32'h0 : wshb_dat_sm;
`endif

    assign wshb_adr    = adr_q;
    assign wshb_we     = 1'b0;
    assign wshb_sel    = 4'hF;
    assign wshb_bte    = 2'b00;
    assign wshb_dat_ms = 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wshb_cyc  = 1'b0;
        wshb_stb  = 1'b0;
        wshb_cti  = 3'b000;
        case (state)
            IDLE: begin
                if (room && !frame_sync && !discard) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                wshb_cyc = 1'b1;
                wshb_stb = 1'b1;
                wshb_cti = last_beat ? 3'b111 : 3'b010;
                if (beat_fail || (beat_ok && last_beat)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address, pixel and beat counters; a frame_sync inside a burst is deferred to the burst's end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q    <= BASE_ADDR;
            pix_cnt  <= 32'h0;
            beat_cnt <= '0;
            discard  <= 1'b0;
        end else if (beat_fail) begin
            if (discard || frame_sync) begin
                adr_q    <= BASE_ADDR;
                pix_cnt  <= 32'h0;
                beat_cnt <= '0;
                discard  <= 1'b0;
            end
        end else if (beat_ok) begin
            if (last_beat) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (last_beat && (discard || frame_sync)) begin
                adr_q   <= BASE_ADDR;
                pix_cnt <= 32'h0;
                discard <= 1'b0;
            end else begin
                if (pix_cnt == LAST_PIX) begin
                    adr_q   <= BASE_ADDR;
                    pix_cnt <= 32'h0;
                end else begin
                    adr_q   <= adr_q + 32'd4;
                    pix_cnt <= pix_cnt + 32'd1;
                end
                if (frame_sync) begin
                    discard <= 1'b1;
                end
            end
        end else if (frame_sync) begin
            if (in_burst) begin
                discard <= 1'b1;
            end else begin
                adr_q    <= BASE_ADDR;
                pix_cnt  <= 32'h0;
                beat_cnt <= '0;
            end
        end
    end

    assign push      = beat_ok & ~discard & ~frame_sync;
    assign pop       = pix_rd & ~pix_empty & ~frame_sync;
    assign pix_empty = (count == '0);
    assign free      = CNT_W'(FIFO_DEPTH) - count;
    assign room      = (free >= CNT_W'(BURST_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (frame_sync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign pix_data = pix_empty ? 32'h0 : mem[rd_ptr];

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Bench for wshb_frame_reader: a queue-based model of fetch order, FIFO contents and bus timing checked
// every cycle, plus directed scenarios with literal expectations (small frame: 8x4, bursts of 8, FIFO of 32).
`timescale 1ns/1ps
module tb_wshb_frame_reader;
    localparam int          HDISP      = 8;
    localparam int          VDISP      = 4;
    localparam int          BURST_LEN  = 8;
    localparam int          FIFO_DEPTH = 32;
    localparam logic [31:0] BASE       = 32'h0000_1000;
    localparam int          TOTAL      = HDISP * VDISP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] wshb_adr;
    logic        wshb_cyc;
    logic        wshb_stb;
    logic        wshb_we;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [31:0] wshb_dat_ms;
    logic [31:0] wshb_dat_sm = 32'h0;
    logic        wshb_ack = 1'b0;
    logic        wshb_err = 1'b0;
    logic        wshb_rty = 1'b0;
    logic        frame_sync = 1'b0;
    logic        pix_rd = 1'b0;
    logic [31:0] pix_data;
    logic        pix_empty;

    always #5 clk = ~clk;

    wshb_frame_reader #(
        .HDISP(HDISP), .VDISP(VDISP), .BASE_ADDR(BASE),
        .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wshb_adr(wshb_adr), .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we),
        .wshb_sel(wshb_sel), .wshb_cti(wshb_cti), .wshb_bte(wshb_bte), .wshb_dat_ms(wshb_dat_ms),
        .wshb_dat_sm(wshb_dat_sm), .wshb_ack(wshb_ack), .wshb_err(wshb_err), .wshb_rty(wshb_rty),
        .frame_sync(frame_sync), .pix_rd(pix_rd), .pix_data(pix_data), .pix_empty(pix_empty)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] q[$];
    logic [31:0] m_adr;
    int          m_pix, m_idx;
    bit          m_disc, exp_cyc, prev_cyc, toggle, have_last_beat;
    int          bursts, beats, burst_cycles, burst_beats, last_burst_cycles, last_burst_beats;
    int          wrap_seen, pops;
    logic [31:0] last_start_adr, last_beat_adr;
    logic [15:0] serial;
    int          ack_mode = 0;
    int          err_beat = -1;
    int          err_burst = 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_adr = BASE; m_pix = 0; m_idx = 0; m_disc = 1'b0;
        exp_cyc = 1'b0; prev_cyc = 1'b0; toggle = 1'b0; have_last_beat = 1'b0;
        bursts = 0; beats = 0; burst_cycles = 0; burst_beats = 0;
        last_burst_cycles = 0; last_burst_beats = 0; wrap_seen = 0; pops = 0;
        last_start_adr = 32'h0; last_beat_adr = 32'h0; serial = 16'h0;
        wshb_ack = 1'b0; wshb_err = 1'b0; wshb_rty = 1'b0;
    endtask

    task automatic advance();
        if (m_pix == TOTAL - 1) begin
            m_adr = BASE;
            m_pix = 0;
        end else begin
            m_adr = m_adr + 32'd4;
            m_pix++;
        end
    endtask

    // Runs at the falling edge: check outputs, drive the slave, predict the effect of the coming rising edge.
    task automatic monitor_step();
        bit          fs, rd, beat, fail, last;
        logic [31:0] dat;
        if (!rst_n) begin
            model_reset();
            chk("rst_cyc", 32'(wshb_cyc), 32'd0);
            chk("rst_stb", 32'(wshb_stb), 32'd0);
            chk("rst_cti", 32'(wshb_cti), 32'd0);
            chk("rst_adr", wshb_adr, BASE);
            chk("rst_empty", 32'(pix_empty), 32'd1);
            chk("rst_pix_data", pix_data, 32'h0);
            return;
        end
        chk("cyc", 32'(wshb_cyc), 32'(exp_cyc));
        chk("stb", 32'(wshb_stb), 32'(exp_cyc));
        chk("pix_empty", 32'(pix_empty), 32'(q.size() == 0));
        if (q.size() > 0) chk("pix_data", pix_data, q[0]);
        chk("we", 32'(wshb_we), 32'd0);
        chk("sel", 32'(wshb_sel), 32'hF);
        chk("bte", 32'(wshb_bte), 32'd0);
        chk("dat_ms", wshb_dat_ms, 32'h0);
        if (wshb_cyc) begin
            chk("adr", wshb_adr, m_adr);
            chk("cti", 32'(wshb_cti), (m_idx == BURST_LEN - 1) ? 32'd7 : 32'd2);
            if (!prev_cyc) begin
                bursts++;
                last_start_adr = wshb_adr;
                burst_cycles = 0;
                burst_beats = 0;
            end
            burst_cycles++;
        end
        prev_cyc = wshb_cyc;

        wshb_ack = 1'b0; wshb_err = 1'b0; wshb_rty = 1'b0;
        if (wshb_cyc && wshb_stb) begin
            if (err_beat >= 0 && bursts == err_burst && m_idx == err_beat) wshb_err = 1'b1;
            else if (ack_mode == 0) wshb_ack = 1'b1;
            else begin
                wshb_ack = toggle;
                toggle = !toggle;
            end
        end else begin
            toggle = 1'b0;
        end
        wshb_dat_sm = {serial, wshb_adr[15:0]};

        fs = frame_sync;
        rd = pix_rd;
`ifdef WSHB_ERR_RETRY_EN
        fail = wshb_cyc && (wshb_err || wshb_rty);
        beat = wshb_cyc && wshb_ack && !fail;
`else
        fail = 1'b0;
        beat = wshb_cyc && (wshb_ack || wshb_err || wshb_rty);
`endif
        last = beat && (m_idx == BURST_LEN - 1);
        if (wshb_cyc) exp_cyc = !(last || fail);
        else exp_cyc = !fs && (FIFO_DEPTH - q.size() >= BURST_LEN);

        if (rd && !fs && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
        end
        dat = (wshb_err || wshb_rty) ? 32'h0 : wshb_dat_sm;
        if (beat && !m_disc && !fs) q.push_back(dat);
        if (fs) q.delete();

        if (beat) begin
            beats++;
            burst_beats++;
            serial++;
            if (have_last_beat && last_beat_adr == BASE + 32'(4 * (TOTAL - 1)) && wshb_adr == BASE)
                wrap_seen++;
            last_beat_adr = wshb_adr;
            have_last_beat = 1'b1;
        end
        if (last || fail) begin
            last_burst_cycles = burst_cycles;
            last_burst_beats = burst_beats;
        end

        if (fail) begin
            if (m_disc || fs) begin
                m_adr = BASE; m_pix = 0; m_idx = 0; m_disc = 1'b0;
            end
        end else if (beat) begin
            if (last) begin
                m_idx = 0;
                if (m_disc || fs) begin
                    m_adr = BASE; m_pix = 0; m_disc = 1'b0;
                end else begin
                    advance();
                end
            end else begin
                m_idx++;
                advance();
                if (fs) m_disc = 1'b1;
            end
        end else if (fs) begin
            if (wshb_cyc) m_disc = 1'b1;
            else begin
                m_adr = BASE; m_pix = 0; m_idx = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input logic v, input string name);
        int n = 0;
        while (wshb_cyc !== v && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (wshb_cyc !== v) begin
            fails++;
            $display("FAIL %s: cyc stuck at %b, wanted %b within 200 cycles", name, wshb_cyc, v);
        end
    endtask

    task automatic wait_idx(input int k, input string name);
        int n = 0;
        while (!(wshb_cyc === 1'b1 && m_idx == k) && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (!(wshb_cyc === 1'b1 && m_idx == k)) begin
            fails++;
            $display("FAIL %s: beat %0d never reached, at beat %0d", name, k, m_idx);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;

        // Fill with no reader: whole FIFO in bursts of 8, then the bus goes quiet.
        ack_mode = 0; pix_rd = 1'b0;
        do_reset();
        repeat (60) tick();
        chk("t1_bursts", 32'(bursts), 32'd4);
        chk("t1_beats", 32'(beats), 32'd32);
        chk("t1_cyc_quiet", 32'(wshb_cyc), 32'd0);
        chk("t1_not_empty", 32'(pix_empty), 32'd0);
        chk("t1_model_fill", 32'(q.size()), 32'd32);
        chk("t1_last_start", last_start_adr, BASE + 32'd96);
        pix_rd = 1'b1;
        repeat (40) tick();
        pix_rd = 1'b0;

        // Slave acks every other cycle: 8 beats take 16 cycles.
        ack_mode = 1;
        do_reset();
        wait_cyc(1'b1, "t2_start");
        wait_cyc(1'b0, "t2_end");
        chk("t2_burst_cycles", 32'(last_burst_cycles), 32'd16);
        chk("t2_burst_beats", 32'(last_burst_beats), 32'd8);

        // Continuous reading across several frame wraps.
        ack_mode = 0; pix_rd = 1'b1;
        do_reset();
        repeat (200) tick();
        chk("t3_wraps", 32'(wrap_seen >= 2), 32'd1);
        chk("t3_pops", 32'(pops > 150), 32'd1);
        pix_rd = 1'b0;

        // frame_sync on beat 5: rest of burst dropped, next burst from the base.
        do_reset();
        wait_idx(5, "t4_beat5");
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        wait_cyc(1'b0, "t4_end");
        chk("t4_empty", 32'(pix_empty), 32'd1);
        chk("t4_idle_adr", wshb_adr, BASE);
        wait_cyc(1'b1, "t4_restart");
        chk("t4_restart_adr", wshb_adr, BASE);

        // Bus error on beat 3 of the first burst.
        err_beat = 3;
        do_reset();
        wait_cyc(1'b1, "t5_start");
        wait_cyc(1'b0, "t5_end");
`ifdef WSHB_ERR_RETRY_EN
        chk("t5_partial", 32'(q.size()), 32'd3);
        wait_cyc(1'b1, "t5_retry");
        chk("t5_retry_adr", wshb_adr, BASE + 32'd12);
        wait_cyc(1'b0, "t5_retry_end");
        chk("t5_retry_beats", 32'(last_burst_beats), 32'd5);
        chk("t5_total", 32'(q.size()), 32'd8);
`else
        chk("t5_full_burst", 32'(q.size()), 32'd8);
        chk("t5_model_zero", q[3], 32'h0);
        pix_rd = 1'b1;
        repeat (3) tick();
        pix_rd = 1'b0;
        chk("t5_head_not_empty", 32'(pix_empty), 32'd0);
        chk("t5_zero_pixel", pix_data, 32'h0);
`endif
        err_beat = -1;

        // Asynchronous reset in the middle of a burst.
        do_reset();
        wait_idx(4, "t6_beat4");
        rst_n = 1'b0;
        #1;
        chk("t6_cyc", 32'(wshb_cyc), 32'd0);
        chk("t6_stb", 32'(wshb_stb), 32'd0);
        chk("t6_empty", 32'(pix_empty), 32'd1);
        chk("t6_adr", wshb_adr, BASE);
        chk("t6_pix_data", pix_data, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        pix_rd = 1'b1;
        repeat (40) tick();
        pix_rd = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
